// File: rtl/lieat_icache_axi_slave.sv
// Cache-line refill slave: takes one AXI-style read address from the icache and returns
// BEATS 64-bit beats fetched one by one from a simple in-order backing memory.
module lieat_icache_axi_slave #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned BEATS = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            icache_axi_arvalid,
    output logic            icache_axi_arready,
    input  logic [XLEN-1:0] icache_axi_araddr,
    output logic            icache_axi_rvalid,
    input  logic            icache_axi_rready,
    output logic [63:0]     icache_axi_rdata,
    output logic            mem_rd_valid,
    input  logic            mem_rd_ready,
    output logic [XLEN-1:0] mem_rd_addr,
    input  logic            mem_rsp_valid,
    input  logic [63:0]     mem_rsp_data
);
    localparam int unsigned     CntW     = $clog2(BEATS) + 1;
    localparam logic [XLEN-1:0] OffMask  = XLEN'(BEATS * 8 - 1);
    localparam logic [CntW-1:0] NumBeats = CntW'(BEATS);
    localparam logic [CntW-1:0] LastBeat = CntW'(BEATS - 1);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] base_q, base_d;
    logic [CntW-1:0] issue_cnt_q, issue_cnt_d;
    logic [CntW-1:0] ret_cnt_q, ret_cnt_d;
    logic [1:0]      outstanding_q, outstanding_d;
    logic [1:0]      fifo_cnt_q, fifo_cnt_d;
    logic [63:0]     fifo_q [2];
    logic            wr_ptr_q, rd_ptr_q;

    logic       ar_fire, req_fire, rsp_ok, rsp_dec, push, pop;
    logic [2:0] credit_used;

    always_comb begin
        icache_axi_arready = (state_q == StIdle) && !reset;
        icache_axi_rvalid  = (fifo_cnt_q != 2'd0);
        icache_axi_rdata   = fifo_q[rd_ptr_q];
        pop                = icache_axi_rvalid && icache_axi_rready;
        // An entry leaving the FIFO this cycle frees its credit at once, so a one-cycle
        // memory can stream a beat every cycle.
        credit_used  = {1'b0, fifo_cnt_q} - {2'b00, pop} + {1'b0, outstanding_q};
        mem_rd_valid = (state_q == StBurst) && (issue_cnt_q < NumBeats) && (credit_used < 3'd2);
        mem_rd_addr  = base_q + XLEN'({issue_cnt_q, 3'b000});
        ar_fire      = icache_axi_arvalid && icache_axi_arready;
        req_fire     = mem_rd_valid && mem_rd_ready;
        rsp_ok       = mem_rsp_valid && (state_q == StBurst);
        rsp_dec      = rsp_ok && (outstanding_q != 2'd0);
        push         = rsp_ok && ((fifo_cnt_q != 2'd2) || pop);
    end

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        issue_cnt_d   = issue_cnt_q;
        ret_cnt_d     = ret_cnt_q;
        outstanding_d = outstanding_q;
        fifo_cnt_d    = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        unique case (state_q)
            StIdle: begin
                if (ar_fire) begin
                    state_d       = StBurst;
                    base_d        = icache_axi_araddr & ~OffMask;
                    issue_cnt_d   = '0;
                    ret_cnt_d     = '0;
                    outstanding_d = '0;
                end
            end
            StBurst: begin
                if (req_fire) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
                case ({req_fire, rsp_dec})
                    2'b10:   outstanding_d = outstanding_q + 2'd1;
                    2'b01:   outstanding_d = outstanding_q - 2'd1;
                    default: outstanding_d = outstanding_q;
                endcase
                if (pop) begin
                    ret_cnt_d = ret_cnt_q + 1'b1;
                    if (ret_cnt_q == LastBeat) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            base_q        <= '0;
            issue_cnt_q   <= '0;
            ret_cnt_q     <= '0;
            outstanding_q <= '0;
            fifo_cnt_q    <= '0;
            fifo_q[0]     <= '0;
            fifo_q[1]     <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            issue_cnt_q   <= issue_cnt_d;
            ret_cnt_q     <= ret_cnt_d;
            outstanding_q <= outstanding_d;
            fifo_cnt_q    <= fifo_cnt_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= mem_rsp_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_lieat_icache_axi_slave.sv
// Scoreboard bench for lieat_icache_axi_slave: a line-level model predicts beat addresses,
// data and handshake availability; a negedge monitor compares against the DUT.
module tb_lieat_icache_axi_slave;
    localparam int BEATS = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] araddr = '0;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [63:0] rdata;
    logic        mem_rd_valid;
    logic        mem_rd_ready = 1'b1;
    logic [31:0] mem_rd_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rsp_data = '0;

    lieat_icache_axi_slave #(.XLEN(32), .BEATS(BEATS)) dut (
        .clock              (clock),
        .reset              (reset),
        .icache_axi_arvalid (arvalid),
        .icache_axi_arready (arready),
        .icache_axi_araddr  (araddr),
        .icache_axi_rvalid  (rvalid),
        .icache_axi_rready  (rready),
        .icache_axi_rdata   (rdata),
        .mem_rd_valid       (mem_rd_valid),
        .mem_rd_ready       (mem_rd_ready),
        .mem_rd_addr        (mem_rd_addr),
        .mem_rsp_valid      (mem_rsp_valid),
        .mem_rsp_data       (mem_rsp_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rem = 0;
    int          issued = 0;
    int          popped = 0;
    int          ar_cyc = 0;
    int          last_due = 0;
    int          lat_max = 0;
    int          rr_lo = 0;
    int          stall_cnt = 0;
    bit          rnd = 0;
    bit          stall_en = 0;
    bit          stray = 0;
    bit          post_rst = 0;
    bit          hold_v = 0;
    logic [63:0] hold_d;
    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_data_q[$];
    pend_t       pend_q[$];
    int          rcyc_q[$];

    function automatic logic [63:0] mdata(input logic [31:0] a);
        return {a ^ 32'h5A5A_1234, ~a + 32'd7};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL timeout %s: got no event, expected one within budget (cycle %0d)", name, cyc);
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor + scoreboard.
    always @(negedge clock) begin
        if (reset) begin
            check("rst_arready", arready, 0);
            check("rst_rvalid", rvalid, 0);
            check("rst_rdata", rdata, 0);
            check("rst_mem_rd_valid", mem_rd_valid, 0);
            check("rst_mem_rd_addr", mem_rd_addr, 0);
            exp_addr_q.delete();
            exp_data_q.delete();
            pend_q.delete();
            rem = 0;
            issued = 0;
            popped = 0;
            hold_v = 0;
            post_rst = 1;
        end else begin
            automatic int pop_now = (rvalid && rready) ? 1 : 0;
            automatic logic exp_mv = (rem > 0) && (issued < BEATS) && (issued - popped - pop_now < 2);
            if (post_rst) begin
                check("arready_after_reset", arready, 1);
                post_rst = 0;
            end
            check("arready", arready, rem == 0);
            check("mem_rd_valid", mem_rd_valid, exp_mv);
            if (mem_rd_valid && exp_addr_q.size() > 0) check("mem_rd_addr", mem_rd_addr, exp_addr_q[0]);
            if (rem == 0) check("rvalid_idle", rvalid, 0);
            if (hold_v) begin
                check("rvalid_hold", rvalid, 1);
                check("rdata_hold", rdata, hold_d);
            end
            if (mem_rd_valid && mem_rd_ready) begin
                automatic pend_t p;
                automatic int d = cyc + 1 + $urandom_range(0, lat_max);
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                p.addr = mem_rd_addr;
                p.due = d;
                pend_q.push_back(p);
                if (exp_addr_q.size() > 0) void'(exp_addr_q.pop_front());
                issued++;
            end
            if (pop_now != 0) begin
                if (exp_data_q.size() == 0) check("rdata_unexpected", rvalid, 0);
                else check("rdata", rdata, exp_data_q.pop_front());
                popped++;
                rem--;
                rcyc_q.push_back(cyc);
            end
            hold_v = rvalid && !rready;
            hold_d = rdata;
            if (arvalid && arready) begin
                automatic logic [31:0] base = araddr & ~32'(BEATS * 8 - 1);
                for (int i = 0; i < BEATS; i++) begin
                    exp_addr_q.push_back(base + 32'(i * 8));
                    exp_data_q.push_back(mdata(base + 32'(i * 8)));
                end
                rem = BEATS;
                issued = 0;
                popped = 0;
                ar_cyc = cyc;
            end
        end
    end

    // Backing memory: in order, never stalls, latency 1..1+lat_max cycles.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (stray) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data = 64'hDEAD_BEEF_0BAD_F00D;
                stray = 0;
            end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                automatic pend_t p = pend_q.pop_front();
                mem_rsp_valid = 1'b1;
                mem_rsp_data = mdata(p.addr);
            end else begin
                mem_rsp_valid = 1'b0;
            end
        end
    end

    // Handshake policy for rready / mem_rd_ready.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rr_lo > 0) begin
                rready = 1'b0;
                rr_lo--;
            end else rready = rnd ? (($urandom % 4) != 0) : 1'b1;
            if (stall_en && issued == 2 && stall_cnt < 3) begin
                mem_rd_ready = 1'b0;
                stall_cnt++;
            end else mem_rd_ready = rnd ? (($urandom % 3) != 0) : 1'b1;
        end
    end

    task automatic do_ar(input logic [31:0] a);
        int n = 0;
        arvalid = 1'b1;
        araddr = a;
        @(negedge clock);
        while (arready !== 1'b1 && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (n >= 300) timeout("arready");
        @(posedge clock);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clock);
        while ((rem != 0 || pend_q.size() != 0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (n >= budget) timeout("burst_done");
        @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Basic fill with latency/throughput checks.
        rcyc_q.delete();
        do_ar(32'h8000_0014);
        wait_idle(100);
        check("fill_beats", rcyc_q.size(), BEATS);
        if (rcyc_q.size() == BEATS) begin
            check("fill_first_latency", rcyc_q[0] - ar_cyc, 3);
            check("fill_streaming", rcyc_q[BEATS-1] - rcyc_q[0], BEATS - 1);
        end

        // Backpressure on the R channel.
        rr_lo = 9;
        do_ar(32'h0000_2238);
        wait_idle(100);

        // Memory stall on beat 2.
        stall_en = 1;
        stall_cnt = 0;
        do_ar(32'h0000_3300);
        wait_idle(100);
        check("stall_cycles", stall_cnt, 3);
        stall_en = 0;

        // Back-to-back: second AR held high during first burst.
        rcyc_q.delete();
        do_ar(32'h0000_0400);
        do_ar(32'h0000_1040);
        check("b2b_first_beats", rcyc_q.size(), BEATS);
        if (rcyc_q.size() == BEATS) check("b2b_ar_gap", ar_cyc - rcyc_q[BEATS-1], 1);
        wait_idle(100);

        // Top-of-space line.
        do_ar(32'hFFFF_FFE0);
        wait_idle(100);

        // Reset after two beats returned, stray response in IDLE, then a fresh burst.
        begin
            int n = 0;
            arvalid = 1'b1;
            araddr = 32'h0000_0200;
            while (popped < 2 && n < 200) begin
                @(negedge clock);
                n++;
            end
            if (n >= 200) timeout("two_beats");
            @(posedge clock);
            #1;
            arvalid = 1'b0;
            reset = 1'b1;
            repeat (2) @(posedge clock);
            #1;
            reset = 1'b0;
            @(posedge clock);
            #1;
            stray = 1;
            repeat (3) @(posedge clock);
            #1;
            do_ar(32'h0000_0100);
            wait_idle(100);
        end

        // Randomized traffic.
        rnd = 1;
        lat_max = 2;
        for (int i = 0; i < 25; i++) begin
            automatic logic [31:0] a = $urandom;
            if (i % 7 == 3) a = 32'hFFFF_FF00 | ($urandom % 256);
            do_ar(a);
            if ($urandom % 2 == 0) wait_idle(400);
        end
        wait_idle(400);
        rnd = 0;
        lat_max = 0;
        wait_idle(50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
